// File: rtl/tdc_test_pulser_if.sv
// Control/status bundle between slow-control logic and the TDC test pulser.
interface tdc_test_pulser_if #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_count;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             stamp_valid;
    logic [TS_W-1:0]  stamp;
    logic [CNT_W-1:0] pulse_idx;

    // Slow-control side: issues requests and configuration, observes status.
    modport master (
        output start, stop, cfg_delay, cfg_width, cfg_period, cfg_count,
        input  pulse_out, busy, done, stamp_valid, stamp, pulse_idx
    );

    // Pulser side.
    modport slave (
        input  start, stop, cfg_delay, cfg_width, cfg_period, cfg_count,
        output pulse_out, busy, done, stamp_valid, stamp, pulse_idx
    );
endinterface

// File: rtl/tdc_test_pulser.sv
// Programmable burst pulse generator for TDC self-test. Every rising edge of
// pulse_out is stamped with a free-running time counter and a pulse index.
module tdc_test_pulser #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdc_test_pulser_if.slave     bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_width_m1;
    logic [CNT_W-1:0] r_low_m1;
    logic [CNT_W-1:0] r_count;
    logic             r_first;
    logic [TS_W-1:0]  r_tcnt;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;
    logic             r_sv;
    logic [TS_W-1:0]  r_stamp;
    logic [CNT_W-1:0] r_idx;

    logic [CNT_W-1:0] w_width_eff;
    logic [CNT_W:0]   w_width_p1;
    logic [CNT_W:0]   w_period_ext;
    logic [CNT_W:0]   w_low_ext;
    logic [CNT_W-1:0] w_low_m1;
    logic [CNT_W-1:0] w_next_idx;
    logic             w_last;
    logic             w_cnt_zero;

    // Effective width/period: width 0 becomes 1, period is stretched so that
    // at least one low cycle separates pulses. Widened by one bit so W+1 can
    // not overflow when cfg_width is all ones.
    always_comb begin
        w_width_eff  = (bus.cfg_width == '0) ? CNT_W'(1) : bus.cfg_width;
        w_width_p1   = {1'b0, w_width_eff} + (CNT_W+1)'(1);
        w_period_ext = ({1'b0, bus.cfg_period} < w_width_p1) ? w_width_p1
                                                             : {1'b0, bus.cfg_period};
        w_low_ext    = w_period_ext - w_width_p1;
        w_low_m1     = w_low_ext[CNT_W-1:0];
        w_next_idx   = r_first ? '0 : r_idx + CNT_W'(1);
        w_last       = (r_count != '0) && (r_idx == r_count - CNT_W'(1));
        w_cnt_zero   = (r_cnt == '0);
    end

    // Free-running time counter, only cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TS_W'(1);
        end
    end

    // Burst sequencer: IDLE -> DELAY -> (HIGH <-> LOW) -> IDLE, stop aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sv    <= 1'b0;
            r_stamp <= '0;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_sv   <= 1'b0;
            if (r_state != S_IDLE && bus.stop) begin
                // Abort: a pulse that already rose stays counted as stamped.
                r_state <= S_IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            r_state <= S_DELAY;
                            r_busy  <= 1'b1;
                            r_cnt   <= bus.cfg_delay;
                            r_first <= 1'b1;
                        end
                    end
                    S_DELAY, S_LOW: begin
                        if (w_cnt_zero) begin
                            // Rising edge: the stamp is the counter value
                            // visible during the first high cycle.
                            r_state <= S_HIGH;
                            r_pulse <= 1'b1;
                            r_sv    <= 1'b1;
                            r_stamp <= r_tcnt + TS_W'(1);
                            r_idx   <= w_next_idx;
                            r_first <= 1'b0;
                            r_cnt   <= r_width_m1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if (w_last) begin
                            r_state <= S_IDLE;
                            r_pulse <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOW;
                            r_pulse <= 1'b0;
                            r_cnt   <= r_low_m1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Burst configuration is frozen at start acceptance; pure data, no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start && !bus.stop) begin
            r_width_m1 <= w_width_eff - CNT_W'(1);
            r_low_m1   <= w_low_m1;
            r_count    <= bus.cfg_count;
        end
    end

    assign bus.pulse_out   = r_pulse;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.stamp_valid = r_sv;
    assign bus.stamp       = r_stamp;
    assign bus.pulse_idx   = r_idx;

endmodule
